// File: rtl/regfile_master_pkg.sv
// Shared op codes, FSM states and RegisterFile address map for regfile_master.
package regfile_master_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_MOVE  = 2'b10,
    OP_INC   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_RSP
  } state_e;

  localparam int REG_K00    = 8;
  localparam int REG_K01    = 9;
  localparam int REG_KFF    = 10;
  localparam int REG_WR_MAX = 3;

endpackage

// File: rtl/register_file.sv
// Single-port RegisterFile: writable registers 0..WR_MAX, constant registers above,
// registered read data one cycle after the select. No reset on the storage.
module RegisterFile
  import regfile_master_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4,
  parameter int WR_MAX = REG_WR_MAX
) (
  input  logic              i_clk,
  input  logic              i_ldSig,
  input  logic [SEL_W-1:0]  i_regSel,
  input  logic [DATA_W-1:0] i_regData,
  output logic [DATA_W-1:0] o_regData
);

  localparam logic [SEL_W-1:0] WR_MAX_SEL = SEL_W'(WR_MAX);

  logic [DATA_W-1:0] regs_q [0:(2**SEL_W)-1];
  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] rd_q;

  always_comb begin
    rd_d = '0;
    if (i_regSel <= WR_MAX_SEL) begin
      rd_d = regs_q[i_regSel];
    end else if (i_regSel == SEL_W'(REG_K00)) begin
      rd_d = '0;
    end else if (i_regSel == SEL_W'(REG_K01)) begin
      rd_d = DATA_W'(1);
    end else if (i_regSel == SEL_W'(REG_KFF)) begin
      rd_d = '1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_ldSig && (i_regSel <= WR_MAX_SEL)) begin
      regs_q[i_regSel] <= i_regData;
    end
    rd_q <= rd_d;
  end

  assign o_regData = rd_q;

endmodule

// File: rtl/regfile_master.sv
// Command-driven initiator for the RegisterFile (READ/WRITE/MOVE, INC when
// REGFILE_MASTER_INC_EN is defined; otherwise op 11 is rejected).
module regfile_master
  import regfile_master_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4,
  parameter int WR_MAX = REG_WR_MAX
) (
  input  logic              i_clk,
  input  logic              i_rstN,
  input  logic              i_cmdValid,
  output logic              o_cmdReady,
  input  logic [1:0]        i_cmdOp,
  input  logic [SEL_W-1:0]  i_cmdDst,
  input  logic [SEL_W-1:0]  i_cmdSrc,
  input  logic [DATA_W-1:0] i_cmdData,
  output logic              o_rspValid,
  input  logic              i_rspReady,
  output logic [DATA_W-1:0] o_rspData,
  output logic              o_rspErr,
  output logic              o_ldSig,
  output logic [SEL_W-1:0]  o_regSel,
  output logic [DATA_W-1:0] o_regData,
  input  logic [DATA_W-1:0] i_regData
);

  localparam logic [SEL_W-1:0] WR_MAX_SEL = SEL_W'(WR_MAX);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [SEL_W-1:0]  dst_q, dst_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              ld_q, ld_d;
  logic              reject;
  logic              dst_ok;

  assign o_cmdReady = (state_q == ST_IDLE) && i_rstN;
  assign dst_ok     = (i_cmdDst <= WR_MAX_SEL);

  // Next-state and next-output decode; every file-facing output is registered.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    ld_d        = 1'b0;
    reject      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_cmdValid && o_cmdReady) begin
          op_d  = op_e'(i_cmdOp);
          dst_d = i_cmdDst;
          unique case (op_e'(i_cmdOp))
            OP_READ: begin
              state_d = ST_RD;
              sel_d   = i_cmdDst;
            end
            OP_WRITE: begin
              if (dst_ok) begin
                state_d = ST_WR;
                ld_d    = 1'b1;
                sel_d   = i_cmdDst;
                wdata_d = i_cmdData;
              end else begin
                reject = 1'b1;
              end
            end
            OP_MOVE: begin
              if (dst_ok) begin
                state_d = ST_RD;
                sel_d   = i_cmdSrc;
              end else begin
                reject = 1'b1;
              end
            end
            OP_INC: begin
`ifdef REGFILE_MASTER_INC_EN
              if (dst_ok) begin
                state_d = ST_RD;
                sel_d   = i_cmdDst;
              end else begin
                reject = 1'b1;
              end
`else
              reject = 1'b1;
`endif
            end
            default: reject = 1'b1;
          endcase
          if (reject) begin
            state_d     = ST_RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end
        end
      end
      ST_RD: state_d = ST_CAP;
      ST_CAP: begin
        unique case (op_q)
          OP_READ: begin
            state_d     = ST_RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = i_regData;
          end
          OP_MOVE: begin
            state_d = ST_WR;
            ld_d    = 1'b1;
            sel_d   = dst_q;
            wdata_d = i_regData;
          end
`ifdef REGFILE_MASTER_INC_EN
          OP_INC: begin
            state_d = ST_WR;
            ld_d    = 1'b1;
            sel_d   = dst_q;
            wdata_d = i_regData + DATA_W'(1);
          end
`endif
          default: state_d = ST_IDLE;
        endcase
      end
      ST_WR: begin
        state_d     = ST_RSP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_data_d  = wdata_q;
      end
      ST_RSP: begin
        if (i_rspReady) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      dst_q       <= '0;
      sel_q       <= '0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      ld_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      ld_q        <= ld_d;
    end
  end

  assign o_rspValid = rsp_valid_q;
  assign o_rspData  = rsp_data_q;
  assign o_rspErr   = rsp_err_q;
  assign o_ldSig    = ld_q;
  assign o_regSel   = sel_q;
  assign o_regData  = wdata_q;

endmodule
